// File: rtl/mfp_reset_sequencer.sv
// mfp_reset_sequencer
// Board-level reset and clock bring-up controller for the MIPSfpga DE1-SoC top.
// It pulses the PLL reset and waits for a stable lock. It then releases
// SI_ColdReset and SI_Reset of mfp_system in order. Debounced KEY presses
// request warm or cold resets while the system runs. The block runs on the
// free-running board clock and never on the PLL output.
module mfp_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int COLD_CYCLES        = 64,
    parameter int WARM_CYCLES        = 32,
    parameter int DEBOUNCE_CYCLES    = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       key_cold_n,
    input  logic       key_warm_n,
    output logic       pll_rst,
    output logic       cold_reset,
    output logic       warm_reset,
    output logic       sys_ready,
    output logic       lock_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_COLD      = 3'd2,
        ST_WARM      = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    // A single per-state counter serves PLL_RST, COLD, WARM and the WAIT_LOCK timeout.
    localparam int MAX_PC    = (PLL_RST_CYCLES > COLD_CYCLES) ? PLL_RST_CYCLES : COLD_CYCLES;
    localparam int MAX_WT    = (WARM_CYCLES > LOCK_TIMEOUT) ? WARM_CYCLES : LOCK_TIMEOUT;
    localparam int STATE_MAX = (MAX_PC > MAX_WT) ? MAX_PC : MAX_WT;
    localparam int CNT_W     = $clog2(STATE_MAX + 1);
    localparam int STB_W     = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    // Each "last" value marks the final cycle of its interval, so the exit happens on that edge.
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COLD_LAST = CNT_W'(COLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            lock_sync_q, kc_sync_q, kw_sync_q;
    logic                  lock_s;
    logic [1:0]            key_s;       // bit 0 = cold key, bit 1 = warm key
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            press;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STB_W-1:0]      stable_q, stable_d;
    logic                  timeout;

    logic                  pll_rst_q, cold_q, warm_q, ready_q, lock_err_q;

    // Two-flop synchronisers. Keys reset to the released level and lock resets to unlocked.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            lock_sync_q <= 2'b00;
            kc_sync_q   <= 2'b11;
            kw_sync_q   <= 2'b11;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked};
            kc_sync_q   <= {kc_sync_q[0], key_cold_n};
            kw_sync_q   <= {kw_sync_q[0], key_warm_n};
        end
    end

    assign lock_s = lock_sync_q[1];
    assign key_s  = {kw_sync_q[1], kc_sync_q[1]};

    // Debounce: accept a new key level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press     = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (key_s[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = key_s[k];
                    press[k] = ~key_s[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
                end
            end
        end
    end

    // Next-state logic. Lock loss beats key presses, and a cold press beats a warm press.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s && (stable_q == STB_LAST)) begin
                    state_d = ST_COLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_PLL_RST;
                    timeout = 1'b1;
                end
            end
            ST_COLD: begin
                if (!lock_s)                 state_d = ST_PLL_RST;
                else if (cnt_q == COLD_LAST) state_d = ST_WARM;
            end
            ST_WARM: begin
                if (!lock_s)                 state_d = ST_PLL_RST;
                else if (cnt_q == WARM_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s)       state_d = ST_PLL_RST;
                else if (press[0]) state_d = ST_COLD;
                else if (press[1]) state_d = ST_WARM;
            end
            default: state_d = ST_PLL_RST;
        endcase
    end

    // Counter updates. Any state change clears both counters, and both saturate.
    always_comb begin
        cnt_d    = '0;
        stable_d = '0;
        if (state_d == state_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if ((state_q == ST_WAIT_LOCK) && lock_s) begin
                stable_d = (&stable_q) ? stable_q : stable_q + STB_W'(1);
            end
        end
    end

    // State, counter and debounce registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            stable_q  <= '0;
            deb_q     <= 2'b11;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Outputs are registered from the next state, so they always agree with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            pll_rst_q  <= 1'b1;
            cold_q     <= 1'b1;
            warm_q     <= 1'b1;
            ready_q    <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            pll_rst_q  <= (state_d == ST_PLL_RST);
            cold_q     <= (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_COLD);
            warm_q     <= (state_d != ST_RUN);
            ready_q    <= (state_d == ST_RUN);
            lock_err_q <= lock_err_q | timeout;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign cold_reset = cold_q;
    assign warm_reset = warm_q;
    assign sys_ready  = ready_q;
    assign lock_err   = lock_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Testbench for mfp_reset_sequencer.
// The directed scenarios cover power-up, lock timeout, a lock glitch, key
// presses, lock loss and a reset issued mid-sequence. Randomised traffic
// follows. A cycle-level reference model is compared against every output on
// every cycle.
module tb_mfp_reset_sequencer;

    localparam int PLL_N  = 4;
    localparam int STB_N  = 8;
    localparam int TO_N   = 50;
    localparam int COLD_N = 6;
    localparam int WARM_N = 3;
    localparam int DEB_N  = 5;

    localparam int C_PLL_LOW  = 0;
    localparam int C_ERR_HIGH = 1;
    localparam int C_READY    = 2;
    localparam int C_ST_WAIT  = 3;
    localparam int C_ST_COLD  = 4;

    logic       clk = 1'b0;
    logic       reset, pll_locked, key_cold_n, key_warm_n;
    logic       pll_rst, cold_reset, warm_reset, sys_ready, lock_err;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    mfp_reset_sequencer #(
        .PLL_RST_CYCLES    (PLL_N),
        .LOCK_STABLE_CYCLES(STB_N),
        .LOCK_TIMEOUT      (TO_N),
        .COLD_CYCLES       (COLD_N),
        .WARM_CYCLES       (WARM_N),
        .DEBOUNCE_CYCLES   (DEB_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .key_cold_n(key_cold_n),
        .key_warm_n(key_warm_n),
        .pll_rst   (pll_rst),
        .cold_reset(cold_reset),
        .warm_reset(warm_reset),
        .sys_ready (sys_ready),
        .lock_err  (lock_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model. It tracks time-in-state as cycle stamps and debounces
    // each key over a sliding window of synced samples.
    int               m_st, m_n, m_entry, m_last_low;
    bit               m_err;
    logic             m_l1, m_l2, m_c1, m_c2, m_w1, m_w2, m_dc, m_dw;
    logic [DEB_N-1:0] win_c, win_w;
    int               fill_c, fill_w;

    function automatic void deb_model(input logic s, inout logic [DEB_N-1:0] win,
                                      inout int fill, inout logic deb, output bit pr);
        win = {win[DEB_N-2:0], s};
        if (fill < DEB_N) fill++;
        pr = 1'b0;
        if (fill >= DEB_N && win == {DEB_N{~deb}}) begin
            deb = s;
            pr  = ~s;
        end
    endfunction

    task automatic model_step();
        bit   pc, pw;
        int   el, nx, ones;
        logic ls;
        if (reset) begin
            m_st = 0; m_entry = m_n + 1; m_last_low = m_n; m_err = 1'b0;
            m_l1 = 1'b0; m_l2 = 1'b0; m_c1 = 1'b1; m_c2 = 1'b1; m_w1 = 1'b1; m_w2 = 1'b1;
            m_dc = 1'b1; m_dw = 1'b1; fill_c = 0; fill_w = 0;
        end else begin
            ls = m_l2;
            deb_model(m_c2, win_c, fill_c, m_dc, pc);
            deb_model(m_w2, win_w, fill_w, m_dw, pw);
            el = m_n - m_entry;
            nx = m_st;
            case (m_st)
                0: if (el + 1 >= PLL_N) nx = 1;
                1: begin
                    if (!ls) m_last_low = m_n;
                    ones = m_n - m_last_low;
                    if (ones >= STB_N) nx = 2;
                    else if (el + 1 >= TO_N) begin nx = 0; m_err = 1'b1; end
                end
                2: if (!ls) nx = 0; else if (el + 1 >= COLD_N) nx = 3;
                3: if (!ls) nx = 0; else if (el + 1 >= WARM_N) nx = 4;
                4: if (!ls) nx = 0; else if (pc) nx = 2; else if (pw) nx = 3;
                default: nx = 0;
            endcase
            if (nx != m_st) begin
                m_entry    = m_n + 1;
                m_last_low = m_n;
                m_st       = nx;
            end
            m_l2 = m_l1; m_l1 = pll_locked;
            m_c2 = m_c1; m_c1 = key_cold_n;
            m_w2 = m_w1; m_w1 = key_warm_n;
        end
        m_n++;
    endtask

    function automatic logic [7:0] model_vec();
        logic [2:0] st;
        st = 3'(m_st);
        return {m_st == 0, m_st <= 2, m_st <= 3, m_st == 4, m_err, st};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {pll_rst, cold_reset, warm_reset, sys_ready, lock_err, state};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle_outputs", dut_vec(), model_vec());
    endtask

    function automatic bit cond(input int c);
        case (c)
            C_PLL_LOW:  return pll_rst === 1'b0;
            C_ERR_HIGH: return lock_err === 1'b1;
            C_READY:    return sys_ready === 1'b1;
            C_ST_WAIT:  return state === 3'd1;
            C_ST_COLD:  return state === 3'd2;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int c, input int max_cycles, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cond(c) && n < max_cycles);
        if (!cond(c)) check({tag, "_reached"}, 32'(cond(c)), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t_pll, t_cold, t_warm, seq, prev, first, cnt;
        int lock_cd, kc_cd, kw_cd;
        bit seen;

        m_n = 0; m_st = 0; m_entry = 0; m_last_low = 0; m_err = 1'b0;
        fill_c = 0; fill_w = 0; win_c = '1; win_w = '1;

        // 1: power-up with lock high from the start
        reset = 1'b1; pll_locked = 1'b1; key_cold_n = 1'b1; key_warm_n = 1'b1;
        repeat (3) cycle();
        check("reset_values", dut_vec(), 8'hE0);
        reset = 1'b0;
        n = 0; seq = 0; prev = 0; t_pll = -1; t_cold = -1; t_warm = -1;
        while (sys_ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
            if (int'(state) != prev) begin prev = int'(state); seq = seq * 8 + prev; end
            if (t_pll < 0 && pll_rst === 1'b0)     t_pll = n;
            if (t_cold < 0 && cold_reset === 1'b0) t_cold = n;
            if (t_warm < 0 && warm_reset === 1'b0) t_warm = n;
        end
        check("pll_rst_len", t_pll, PLL_N);
        check("cold_fall", t_cold - t_pll, STB_N + COLD_N);
        check("warm_fall", t_warm - t_cold, WARM_N);
        check("ready_with_warm", n, t_warm);
        check("state_seq", seq, 'o1234);

        // 2: lock never asserts
        reset = 1'b1; pll_locked = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        wait_for("lock_timeout", C_ERR_HIGH, 200, n);
        check("timeout_cycles", n, PLL_N + TO_N);
        check("repulse_pll_rst", pll_rst, 1);
        wait_for("repulse", C_PLL_LOW, 20, n);
        check("repulse_len", n, PLL_N);
        seen = 1'b0;
        repeat (120) begin
            cycle();
            if (sys_ready !== 1'b0) seen = 1'b1;
        end
        check("never_ready", seen, 0);
        check("lock_err_sticky", lock_err, 1);

        // 3: one-cycle lock glitch after 6 stable cycles
        reset = 1'b1; pll_locked = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        wait_for("enter_wait", C_ST_WAIT, 20, n);
        repeat (4) cycle();
        pll_locked = 1'b0;
        cycle();
        pll_locked = 1'b1;
        wait_for("glitch_cold", C_ST_COLD, 40, n);
        check("glitch_restart", n + 5, 6 + 1 + STB_N);

        // 4: warm key held 10 cycles, then a short bounce
        wait_for("reach_run", C_READY, 40, n);
        key_warm_n = 1'b0; first = -1; cnt = 0; seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (warm_reset === 1'b1) begin cnt++; if (first < 0) first = i; end
            if (cold_reset !== 1'b0) seen = 1'b1;
        end
        key_warm_n = 1'b1;
        check("warm_press_delay", first, 2 + DEB_N);
        check("warm_len", cnt, WARM_N);
        check("warm_no_cold", seen, 0);
        repeat (10) cycle();
        check("back_to_run", state, 4);
        seen = 1'b0;
        for (int i = 0; i < 18; i++) begin
            key_warm_n = (i >= 3);
            cycle();
            if (warm_reset !== 1'b0) seen = 1'b1;
        end
        check("bounce_ignored", seen, 0);

        // 5: both keys together, then lock loss during WARM
        key_cold_n = 1'b0; key_warm_n = 1'b0; first = -1; cnt = 0; n = 0;
        while (state !== 3'd3 && n < 40) begin
            cycle();
            n++;
            if (first < 0 && state !== 3'd4) first = int'(state);
            if (cold_reset === 1'b1) cnt++;
        end
        check("both_first_state", first, 2);
        check("both_cold_len", cnt, COLD_N);
        check("both_reach_warm", state, 3);
        pll_locked = 1'b0; key_cold_n = 1'b1; key_warm_n = 1'b1;
        repeat (2) cycle();
        check("warm_before_loss", state, 3);
        cycle();
        check("lock_loss_state", state, 0);
        check("lock_loss_pll_rst", pll_rst, 1);

        // 6: set lock_err, relock, then pulse reset while in COLD
        wait_for("relock_timeout", C_ERR_HIGH, 120, n);
        pll_locked = 1'b1;
        wait_for("reach_cold", C_ST_COLD, 120, n);
        check("err_before_reset", lock_err, 1);
        reset = 1'b1;
        cycle();
        check("mid_cold_reset", dut_vec(), 8'hE0);
        reset = 1'b0;
        wait_for("restart_pll", C_PLL_LOW, 20, n);
        check("restart_pll_len", n, PLL_N);
        check("err_cleared", lock_err, 0);

        // Randomised traffic: lock drops, key presses of random length, rare resets
        lock_cd = 0; kc_cd = 0; kw_cd = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            if (lock_cd > 0) lock_cd--;
            else if ($urandom_range(0, 249) == 0) lock_cd = int'($urandom_range(1, 80));
            if (kc_cd > 0) kc_cd--;
            else if ($urandom_range(0, 59) == 0) kc_cd = int'($urandom_range(1, 12));
            if (kw_cd > 0) kw_cd--;
            else if ($urandom_range(0, 49) == 0) kw_cd = int'($urandom_range(1, 12));
            pll_locked = (lock_cd == 0);
            key_cold_n = (kc_cd == 0);
            key_warm_n = (kw_cd == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
